pipeline_sequencer: RTL and testbench

Hazard and sequencing controller for the 3-stage RISC-V core (F → DX → W). It tracks the instruction held in W and generates the forwarding selects for the DX operands. It also produces the pipeline-register enables and kills for branch/jump redirects, instruction-fetch waits and multi-cycle data-memory accesses. It sits beside the decode control path and consumes the per-instruction control fields that the control path produces.

---
 rtl/pipeline_sequencer.sv | 139 +++++++++++++
 tb/tb_pipeline_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_sequencer.sv
// +----------------------------------------------------------------------------+
// | pipeline_sequencer: hazard, forwarding and stall/kill control for F-DX-W.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module pipeline_sequencer #(
    parameter int REDIRECT_BUBBLES = 1,
    parameter int CNT_W            = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dx_valid_i,
    input  logic [4:0]       dx_rs1_i,
    input  logic [4:0]       dx_rs2_i,
    input  logic             dx_use_rs1_i,
    input  logic             dx_use_rs2_i,
    input  logic [4:0]       dx_rd_i,
    input  logic             dx_reg_write_i,
    input  logic             dx_mem_op_i,
    input  logic             dx_is_load_i,
    input  logic             dx_redirect_i,
    input  logic             imem_ready_i,
    input  logic             dmem_ack_i,
    input  logic             cnt_clr_i,
    output logic             pc_en_o,
    output logic             dx_en_o,
    output logic             dx_kill_o,
    output logic             w_en_o,
    output logic             dmem_req_o,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_MEM_WAIT   = 2'd1,
        ST_REDIRECT   = 2'd2,
        ST_FETCH_WAIT = 2'd3
    } state_t;

    localparam logic [1:0] BUBBLES = 2'(REDIRECT_BUBBLES);

    state_t           state_q, state_d;
    logic [1:0]       bub_q, bub_d;
    logic             w_valid_q, w_reg_write_q, w_mem_op_q, w_is_load_q, w_done_q;
    logic [4:0]       w_rd_q;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             mem_stall;
    logic             kill_in_flight;

    assign dmem_req_o     = w_valid_q & w_mem_op_q & ~w_done_q;
    assign mem_stall      = dmem_req_o & ~dmem_ack_i;
    // Whatever sits in DX while redirecting is a wrong-path fetch.
    assign kill_in_flight = (state_q == ST_REDIRECT);
    assign stall_cnt_o    = stall_cnt_q;
    assign flush_cnt_o    = flush_cnt_q;

    // MEM_WAIT and FETCH_WAIT share the RUN evaluation once the pipe may move,
    // so a redirect held in DX across a memory wait is taken on the ack cycle.
    always_comb begin
        state_d   = state_q;
        bub_d     = bub_q;
        pc_en_o   = 1'b1;
        dx_en_o   = 1'b1;
        w_en_o    = 1'b1;
        dx_kill_o = 1'b0;
        if (mem_stall) begin
            pc_en_o = 1'b0;
            dx_en_o = 1'b0;
            w_en_o  = 1'b0;
            if (state_q == ST_RUN) state_d = ST_MEM_WAIT;
        end else if (state_q == ST_REDIRECT) begin
            dx_kill_o = 1'b1;
            pc_en_o   = imem_ready_i;
            bub_d     = bub_q - 2'd1;
            if (bub_q <= 2'd1) state_d = ST_RUN;
        end else if (dx_valid_i && dx_redirect_i) begin
            dx_kill_o = ~imem_ready_i;
            state_d   = ST_REDIRECT;
            bub_d     = BUBBLES;
        end else if (!imem_ready_i) begin
            pc_en_o   = 1'b0;
            dx_kill_o = 1'b1;
            state_d   = ST_FETCH_WAIT;
        end else begin
            state_d = ST_RUN;
        end
    end

    always_comb begin
        fwd_a_o = 2'b00;
        fwd_b_o = 2'b00;
        if (w_valid_q && w_reg_write_q && (w_rd_q != 5'd0)) begin
            if (dx_use_rs1_i && (w_rd_q == dx_rs1_i)) fwd_a_o = w_is_load_q ? 2'b10 : 2'b01;
            if (dx_use_rs2_i && (w_rd_q == dx_rs2_i)) fwd_b_o = w_is_load_q ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_REDIRECT;
            bub_q         <= BUBBLES;
            w_valid_q     <= 1'b0;
            w_rd_q        <= 5'd0;
            w_reg_write_q <= 1'b0;
            w_mem_op_q    <= 1'b0;
            w_is_load_q   <= 1'b0;
            w_done_q      <= 1'b0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bub_q   <= bub_d;
            if (w_en_o) begin
                w_valid_q     <= dx_valid_i & ~kill_in_flight;
                w_rd_q        <= dx_rd_i;
                w_reg_write_q <= dx_reg_write_i;
                w_mem_op_q    <= dx_mem_op_i;
                w_is_load_q   <= dx_is_load_i;
                w_done_q      <= 1'b0;
            end else if (dmem_req_o && dmem_ack_i) begin
                w_done_q <= 1'b1;
            end
            if (cnt_clr_i) begin
                stall_cnt_q <= '0;
                flush_cnt_q <= '0;
            end else begin
                if (!pc_en_o) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
                if (dx_kill_o && kill_in_flight) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pipeline_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_pipeline_sequencer: directed bench, one instance per bubble count.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_pipeline_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       dx_valid, dx_use_rs1, dx_use_rs2, dx_reg_write, dx_mem_op, dx_is_load, dx_redirect;
    logic [4:0] dx_rs1, dx_rs2, dx_rd;
    logic       imem_ready, dmem_ack, cnt_clr;

    logic        pc_en1, dx_en1, dx_kill1, w_en1, dmem_req1;
    logic [1:0]  fwd_a1, fwd_b1;
    logic [15:0] stall1, flush1;
    logic        pc_en2, dx_en2, dx_kill2, w_en2, dmem_req2;
    logic [1:0]  fwd_a2, fwd_b2;
    logic [15:0] stall2, flush2;

    logic [3:0] ctl1, ctl2;
    assign ctl1 = {pc_en1, dx_en1, w_en1, dx_kill1};
    assign ctl2 = {pc_en2, dx_en2, w_en2, dx_kill2};

    int errors = 0;
    int checks = 0;

    pipeline_sequencer #(.REDIRECT_BUBBLES(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .dx_valid_i(dx_valid), .dx_rs1_i(dx_rs1), .dx_rs2_i(dx_rs2),
        .dx_use_rs1_i(dx_use_rs1), .dx_use_rs2_i(dx_use_rs2), .dx_rd_i(dx_rd),
        .dx_reg_write_i(dx_reg_write), .dx_mem_op_i(dx_mem_op), .dx_is_load_i(dx_is_load),
        .dx_redirect_i(dx_redirect), .imem_ready_i(imem_ready), .dmem_ack_i(dmem_ack),
        .cnt_clr_i(cnt_clr), .pc_en_o(pc_en1), .dx_en_o(dx_en1), .dx_kill_o(dx_kill1),
        .w_en_o(w_en1), .dmem_req_o(dmem_req1), .fwd_a_o(fwd_a1), .fwd_b_o(fwd_b1),
        .stall_cnt_o(stall1), .flush_cnt_o(flush1)
    );

    pipeline_sequencer #(.REDIRECT_BUBBLES(2), .CNT_W(16)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .dx_valid_i(dx_valid), .dx_rs1_i(dx_rs1), .dx_rs2_i(dx_rs2),
        .dx_use_rs1_i(dx_use_rs1), .dx_use_rs2_i(dx_use_rs2), .dx_rd_i(dx_rd),
        .dx_reg_write_i(dx_reg_write), .dx_mem_op_i(dx_mem_op), .dx_is_load_i(dx_is_load),
        .dx_redirect_i(dx_redirect), .imem_ready_i(imem_ready), .dmem_ack_i(dmem_ack),
        .cnt_clr_i(cnt_clr), .pc_en_o(pc_en2), .dx_en_o(dx_en2), .dx_kill_o(dx_kill2),
        .w_en_o(w_en2), .dmem_req_o(dmem_req2), .fwd_a_o(fwd_a2), .fwd_b_o(fwd_b2),
        .stall_cnt_o(stall2), .flush_cnt_o(flush2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_dx(input logic v, input logic [4:0] rd, input logic rw,
                            input logic mem, input logic ld, input logic redir);
        dx_valid     = v;
        dx_rd        = rd;
        dx_reg_write = rw;
        dx_mem_op    = mem;
        dx_is_load   = ld;
        dx_redirect  = redir;
        dx_rs1       = 5'd0;
        dx_rs2       = 5'd0;
        dx_use_rs1   = 1'b0;
        dx_use_rs2   = 1'b0;
    endtask

    task automatic drive_src(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2);
        dx_rs1     = rs1;
        dx_use_rs1 = u1;
        dx_rs2     = rs2;
        dx_use_rs2 = u2;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive_dx(0, 0, 0, 0, 0, 0);
        imem_ready = 1'b1; dmem_ack = 1'b0; cnt_clr = 1'b0;
        repeat (2) tick;
        @(negedge clk);
        checks++; if (ctl1 !== 4'b1111) begin errors++; $display("FAIL reset_ctl1: got %b want 1111", ctl1); end
        checks++; if (ctl2 !== 4'b1111) begin errors++; $display("FAIL reset_ctl2: got %b want 1111", ctl2); end
        checks++; if ({dmem_req1, fwd_a1, fwd_b1} !== 5'b0) begin errors++; $display("FAIL reset_req_fwd: got %b want 00000", {dmem_req1, fwd_a1, fwd_b1}); end
        checks++; if ({stall1, flush1} !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %h want 0", {stall1, flush1}); end
        tick;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (ctl1 !== 4'b1111) begin errors++; $display("FAIL first_kill: got %b want 1111", ctl1); end
        tick;
        @(negedge clk);
        checks++; if (ctl1 !== 4'b1110) begin errors++; $display("FAIL run_after_reset1: got %b want 1110", ctl1); end
        checks++; if (flush1 !== 16'd1) begin errors++; $display("FAIL reset_flush1: got %0d want 1", flush1); end
        checks++; if (ctl2 !== 4'b1111) begin errors++; $display("FAIL second_kill2: got %b want 1111", ctl2); end
        tick;
        cnt_clr = 1'b1;
        @(negedge clk);
        checks++; if (ctl2 !== 4'b1110) begin errors++; $display("FAIL run_after_reset2: got %b want 1110", ctl2); end
        checks++; if (flush2 !== 16'd2) begin errors++; $display("FAIL reset_flush2: got %0d want 2", flush2); end
        checks++; if (stall1 !== 16'd0) begin errors++; $display("FAIL reset_stall1: got %0d want 0", stall1); end
        tick;
        cnt_clr = 1'b0;
        @(negedge clk);
        checks++; if ({flush1, flush2} !== 32'd0) begin errors++; $display("FAIL cnt_clr: got %h want 0", {flush1, flush2}); end
    endtask

    task automatic test_forward;
        tick;
        drive_dx(1, 5, 1, 0, 0, 0);
        tick;
        drive_dx(1, 0, 0, 0, 0, 0); drive_src(5, 1, 5, 1);
        @(negedge clk);
        checks++; if ({fwd_a1, fwd_b1} !== 4'b0101) begin errors++; $display("FAIL fwd_alu1: got %b want 0101", {fwd_a1, fwd_b1}); end
        checks++; if ({fwd_a2, fwd_b2} !== 4'b0101) begin errors++; $display("FAIL fwd_alu2: got %b want 0101", {fwd_a2, fwd_b2}); end
        tick;
        drive_dx(1, 0, 1, 0, 0, 0); drive_src(5, 1, 5, 1);
        @(negedge clk);
        checks++; if ({fwd_a1, fwd_b1} !== 4'b0000) begin errors++; $display("FAIL fwd_nowrite: got %b want 0000", {fwd_a1, fwd_b1}); end
        tick;
        drive_dx(1, 7, 1, 0, 0, 0); drive_src(0, 1, 0, 1);
        @(negedge clk);
        checks++; if ({fwd_a1, fwd_b1} !== 4'b0000) begin errors++; $display("FAIL fwd_x0: got %b want 0000", {fwd_a1, fwd_b1}); end
        tick;
        drive_dx(1, 5, 1, 1, 1, 0); drive_src(7, 1, 7, 0);
        @(negedge clk);
        checks++; if ({fwd_a1, fwd_b1} !== 4'b0100) begin errors++; $display("FAIL fwd_use_rs2: got %b want 0100", {fwd_a1, fwd_b1}); end
        tick;
        drive_dx(1, 0, 0, 0, 0, 0); drive_src(5, 1, 5, 1);
        dmem_ack = 1'b1;
        @(negedge clk);
        checks++; if ({fwd_a1, fwd_b1} !== 4'b1010) begin errors++; $display("FAIL fwd_load: got %b want 1010", {fwd_a1, fwd_b1}); end
        checks++; if ({dmem_req1, ctl1} !== 5'b11110) begin errors++; $display("FAIL load_ack_flow: got %b want 11110", {dmem_req1, ctl1}); end
        tick;
        dmem_ack = 1'b0;
    endtask

    task automatic test_mem_stall;
        drive_dx(1, 0, 0, 1, 0, 0);
        cnt_clr = 1'b1;
        tick;
        cnt_clr = 1'b0;
        drive_dx(1, 3, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if ({dmem_req1, ctl1} !== 5'b10000) begin errors++; $display("FAIL mem_freeze1[%0d]: got %b want 10000", i, {dmem_req1, ctl1}); end
            checks++; if ({dmem_req2, ctl2} !== 5'b10000) begin errors++; $display("FAIL mem_freeze2[%0d]: got %b want 10000", i, {dmem_req2, ctl2}); end
            tick;
        end
        dmem_ack = 1'b1;
        @(negedge clk);
        checks++; if ({dmem_req1, ctl1} !== 5'b11110) begin errors++; $display("FAIL mem_ack_advance: got %b want 11110", {dmem_req1, ctl1}); end
        tick;
        dmem_ack = 1'b0;
        drive_dx(0, 0, 0, 0, 0, 0); drive_src(3, 1, 0, 0);
        @(negedge clk);
        checks++; if ({dmem_req1, fwd_a1} !== 3'b001) begin errors++; $display("FAIL mem_after_ack: got %b want 001", {dmem_req1, fwd_a1}); end
        checks++; if (stall1 !== 16'd3) begin errors++; $display("FAIL mem_stall_cnt1: got %0d want 3", stall1); end
        checks++; if (stall2 !== 16'd3) begin errors++; $display("FAIL mem_stall_cnt2: got %0d want 3", stall2); end
        tick;
    endtask

    task automatic test_redirect;
        drive_dx(1, 0, 0, 0, 0, 1);
        cnt_clr = 1'b1;
        @(negedge clk);
        checks++; if ({ctl1, ctl2} !== 8'b1110_1110) begin errors++; $display("FAIL redir_cycle: got %b want 11101110", {ctl1, ctl2}); end
        tick;
        cnt_clr = 1'b0;
        drive_dx(1, 9, 1, 0, 0, 0);
        @(negedge clk);
        checks++; if ({ctl1, ctl2} !== 8'b1111_1111) begin errors++; $display("FAIL redir_kill1: got %b want 11111111", {ctl1, ctl2}); end
        tick;
        drive_dx(1, 0, 0, 0, 0, 0); drive_src(9, 1, 0, 0);
        @(negedge clk);
        checks++; if ({fwd_a1, fwd_a2} !== 4'b0000) begin errors++; $display("FAIL redir_w_bubble: got %b want 0000", {fwd_a1, fwd_a2}); end
        checks++; if ({ctl1, ctl2} !== 8'b1110_1111) begin errors++; $display("FAIL redir_kill2: got %b want 11101111", {ctl1, ctl2}); end
        tick;
        drive_dx(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if (ctl2 !== 4'b1110) begin errors++; $display("FAIL redir_done2: got %b want 1110", ctl2); end
        checks++; if ({flush1, flush2} !== {16'd1, 16'd2}) begin errors++; $display("FAIL redir_flush: got %0d/%0d want 1/2", flush1, flush2); end
        tick;
    endtask

    task automatic test_redirect_mem;
        drive_dx(1, 4, 1, 1, 1, 0);
        cnt_clr = 1'b1;
        tick;
        cnt_clr = 1'b0;
        drive_dx(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if ({dmem_req1, ctl1, ctl2} !== 9'b1_0000_0000) begin errors++; $display("FAIL rm_freeze[%0d]: got %b want 100000000", i, {dmem_req1, ctl1, ctl2}); end
            tick;
        end
        dmem_ack = 1'b1;
        @(negedge clk);
        checks++; if ({ctl1, ctl2} !== 8'b1110_1110) begin errors++; $display("FAIL rm_ack_redir: got %b want 11101110", {ctl1, ctl2}); end
        tick;
        dmem_ack = 1'b0;
        drive_dx(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if ({ctl1, ctl2} !== 8'b1111_1111) begin errors++; $display("FAIL rm_kill1: got %b want 11111111", {ctl1, ctl2}); end
        tick;
        @(negedge clk);
        checks++; if ({ctl1, ctl2} !== 8'b1110_1111) begin errors++; $display("FAIL rm_kill2: got %b want 11101111", {ctl1, ctl2}); end
        tick;
        @(negedge clk);
        checks++; if (ctl2 !== 4'b1110) begin errors++; $display("FAIL rm_done2: got %b want 1110", ctl2); end
        checks++; if ({flush1, flush2} !== {16'd1, 16'd2}) begin errors++; $display("FAIL rm_flush: got %0d/%0d want 1/2", flush1, flush2); end
        checks++; if ({stall1, stall2} !== {16'd2, 16'd2}) begin errors++; $display("FAIL rm_stall: got %0d/%0d want 2/2", stall1, stall2); end
        tick;
    endtask

    task automatic test_fetch_wait;
        logic [1:0] exp_f;
        drive_dx(1, 6, 1, 0, 0, 0);
        cnt_clr = 1'b1;
        tick;
        cnt_clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            imem_ready = 1'b0;
            drive_dx(0, 0, 0, 0, 0, 0); drive_src(6, 1, 0, 0);
            exp_f = (i == 0) ? 2'b01 : 2'b00;
            @(negedge clk);
            checks++; if ({ctl1, ctl2} !== 8'b0111_0111) begin errors++; $display("FAIL fw_ctl[%0d]: got %b want 01110111", i, {ctl1, ctl2}); end
            checks++; if (fwd_a1 !== exp_f) begin errors++; $display("FAIL fw_drain[%0d]: got %b want %b", i, fwd_a1, exp_f); end
            tick;
        end
        imem_ready = 1'b1;
        @(negedge clk);
        checks++; if ({ctl1, ctl2} !== 8'b1110_1110) begin errors++; $display("FAIL fw_resume: got %b want 11101110", {ctl1, ctl2}); end
        tick;
        @(negedge clk);
        checks++; if ({stall1, stall2} !== {16'd4, 16'd4}) begin errors++; $display("FAIL fw_stall: got %0d/%0d want 4/4", stall1, stall2); end
        checks++; if (flush1 !== 16'd0) begin errors++; $display("FAIL fw_flush: got %0d want 0", flush1); end
        tick;
    endtask

    task automatic test_reset_mid;
        drive_dx(1, 0, 0, 1, 0, 0);
        tick;
        drive_dx(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if ({dmem_req1, ctl1} !== 5'b10000) begin errors++; $display("FAIL rst_mid_stall: got %b want 10000", {dmem_req1, ctl1}); end
        tick;
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if ({dmem_req1, dmem_req2} !== 2'b00) begin errors++; $display("FAIL rst_mid_req: got %b want 00", {dmem_req1, dmem_req2}); end
        checks++; if (ctl1 !== 4'b1111) begin errors++; $display("FAIL rst_mid_ctl: got %b want 1111", ctl1); end
        dmem_ack = 1'b1;
        tick;
        tick;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if ({dmem_req1, ctl1} !== 5'b01111) begin errors++; $display("FAIL rst_late_ack: got %b want 01111", {dmem_req1, ctl1}); end
        checks++; if ({stall1, flush1} !== 32'd0) begin errors++; $display("FAIL rst_mid_cnt: got %h want 0", {stall1, flush1}); end
        tick;
        dmem_ack = 1'b0;
        @(negedge clk);
        checks++; if (ctl1 !== 4'b1110) begin errors++; $display("FAIL rst_mid_run: got %b want 1110", ctl1); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_forward;
        test_mem_stall;
        test_redirect;
        test_redirect_mem;
        test_fetch_wait;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
